// File: rtl/traffic_light_pkg.sv
// Shared encodings for the traffic-light pin protocol.
// Used by both the controller and the receive-side monitor.
package traffic_light_pkg;

    // Monitor phase encodings
    localparam logic [2:0] PH_UNSYNC      = 3'd0;
    localparam logic [2:0] PH_IDLE_BLINK  = 3'd1;
    localparam logic [2:0] PH_RED         = 3'd2;
    localparam logic [2:0] PH_RED_YELLOW  = 3'd3;
    localparam logic [2:0] PH_GREEN       = 3'd4;
    localparam logic [2:0] PH_GREEN_BLINK = 3'd5;
    localparam logic [2:0] PH_YELLOW      = 3'd6;

    // Lamp patterns as {R,Y,G}
    localparam logic [2:0] PAT_OFF = 3'b000;
    localparam logic [2:0] PAT_R   = 3'b100;
    localparam logic [2:0] PAT_RY  = 3'b110;
    localparam logic [2:0] PAT_G   = 3'b001;
    localparam logic [2:0] PAT_Y   = 3'b010;

    // 7-segment codes, bit0=a .. bit6=g, active-high
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    // Default phase timing in clock cycles
    localparam int T_RED_YELLOW_DEF  = 4;
    localparam int T_GREEN_DEF       = 10;
    localparam int T_GREEN_BLINK_DEF = 6;
    localparam int T_YELLOW_DEF      = 4;
    localparam int RED_START_DEF     = 9;

    // True for the two patterns used by the idle amber blink
    function automatic logic is_idle_pat(input logic [2:0] p);
        return (p == PAT_OFF) || (p == PAT_Y);
    endfunction

    // True for any pattern the protocol allows on the pins
    function automatic logic is_legal_pat(input logic [2:0] p);
        return (p == PAT_OFF) || (p == PAT_R) || (p == PAT_RY)
            || (p == PAT_G) || (p == PAT_Y);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 7-segment to BCD digit decoder.
// Any code other than the ten digit glyphs is reported invalid.
module seg7_decoder
    import traffic_light_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] digit
);

    // Map each glyph back to its digit; unknown glyphs read as 0
    always_comb begin
        valid = 1'b1;
        digit = 4'd0;
        case (seg)
            SEG_0: digit = 4'd0;
            SEG_1: digit = 4'd1;
            SEG_2: digit = 4'd2;
            SEG_3: digit = 4'd3;
            SEG_4: digit = 4'd4;
            SEG_5: digit = 4'd5;
            SEG_6: digit = 4'd6;
            SEG_7: digit = 4'd7;
            SEG_8: digit = 4'd8;
            SEG_9: digit = 4'd9;
            default: begin
                valid = 1'b0;
                digit = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side protocol checker for the traffic-light pins.
// Two-stage: pins registered, then phase tracking and error flags.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int T_RED_YELLOW  = T_RED_YELLOW_DEF,
    parameter int T_GREEN       = T_GREEN_DEF,
    parameter int T_GREEN_BLINK = T_GREEN_BLINK_DEF,
    parameter int T_YELLOW      = T_YELLOW_DEF,
    parameter int RED_START     = RED_START_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lamp_r,
    input  logic       lamp_y,
    input  logic       lamp_g,
    input  logic [6:0] seg,
    input  logic       clr_err,
    output logic [2:0] phase,
    output logic [3:0] digit,
    output logic       err_pulse,
    output logic       err_seq,
    output logic       err_dwell,
    output logic       err_seg,
    output logic [7:0] err_count,
    output logic [7:0] cycles_ok
);

    localparam logic [4:0] D_RY  = 5'(T_RED_YELLOW);
    localparam logic [4:0] D_G   = 5'(T_GREEN);
    localparam logic [4:0] D_GB  = 5'(T_GREEN_BLINK);
    localparam logic [4:0] D_Y   = 5'(T_YELLOW);
    localparam logic [3:0] D_RS  = 4'(RED_START);

    // Stage 1: sampled pins
    logic [2:0] s1_pat;
    logic [6:0] s1_seg;
    logic       s1_clr;
    logic       s1_vld;

    // Stage 2: tracking state
    logic [4:0] dwell;
    logic [3:0] prev_dig;
    logic       idle_y;
    logic       round_ok;

    // Decoded sample
    logic       dec_vld;
    logic [3:0] dec_dig;

    // Next-state and error terms
    logic [2:0] nx_phase;
    logic [4:0] dwell_inc;
    logic [4:0] nx_dwell;
    logic       nx_idle_y;
    logic       e_seq;
    logic       e_dwell;
    logic       e_seg;
    logic       err_any;
    logic       red_entry;
    logic       round_done;
    logic       exp_g;

    seg7_decoder u_dec (
        .seg   (s1_seg),
        .valid (dec_vld),
        .digit (dec_dig)
    );

    // Register the raw pins once; s1_vld masks the cleared sample after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_pat <= PAT_OFF;
            s1_seg <= 7'd0;
            s1_clr <= 1'b0;
            s1_vld <= 1'b0;
        end else begin
            s1_pat <= {lamp_r, lamp_y, lamp_g};
            s1_seg <= seg;
            s1_clr <= clr_err;
            s1_vld <= 1'b1;
        end
    end

    assign dwell_inc = (dwell == 5'd31) ? dwell : dwell + 5'd1;
    // Blink cycle k = dwell+1 must be lit when k is even
    assign exp_g     = ~dwell_inc[0];

    // Phase successor rules and per-kind error detection
    always_comb begin
        nx_phase   = phase;
        nx_idle_y  = idle_y;
        e_seq      = 1'b0;
        e_dwell    = 1'b0;
        e_seg      = 1'b0;
        red_entry  = 1'b0;
        round_done = 1'b0;
        case (phase)
            PH_UNSYNC: begin
                if (is_idle_pat(s1_pat)) begin
                    nx_phase  = PH_IDLE_BLINK;
                    nx_idle_y = (s1_pat == PAT_Y);
                end else if (s1_pat == PAT_R) begin
                    nx_phase  = PH_RED;
                    red_entry = 1'b1;
                end
            end
            PH_IDLE_BLINK: begin
                if (is_idle_pat(s1_pat)) begin
                    if ((s1_pat == PAT_Y) == idle_y)
                        e_dwell = 1'b1;
                    nx_idle_y = (s1_pat == PAT_Y);
                end else if (s1_pat == PAT_R) begin
                    nx_phase  = PH_RED;
                    red_entry = 1'b1;
                end else begin
                    e_seq = 1'b1;
                end
            end
            PH_RED: begin
                if (s1_pat == PAT_R) begin
                    if (prev_dig == 4'd0)
                        e_dwell = 1'b1;
                    else if (dec_dig != prev_dig - 4'd1)
                        e_seg = 1'b1;
                end else if (s1_pat == PAT_RY) begin
                    if (prev_dig != 4'd0)
                        e_dwell = 1'b1;
                    else
                        nx_phase = PH_RED_YELLOW;
                end else begin
                    e_seq = 1'b1;
                end
            end
            PH_RED_YELLOW: begin
                if (s1_pat == PAT_RY) begin
                    if (dwell >= D_RY)
                        e_dwell = 1'b1;
                end else if (s1_pat == PAT_G) begin
                    if (dwell != D_RY)
                        e_dwell = 1'b1;
                    else
                        nx_phase = PH_GREEN;
                end else begin
                    e_seq = 1'b1;
                end
            end
            PH_GREEN: begin
                if (s1_pat == PAT_G) begin
                    if (dwell >= D_G)
                        e_dwell = 1'b1;
                end else if (s1_pat == PAT_OFF) begin
                    if (dwell != D_G)
                        e_dwell = 1'b1;
                    else
                        nx_phase = PH_GREEN_BLINK;
                end else begin
                    e_seq = 1'b1;
                end
            end
            PH_GREEN_BLINK: begin
                if (s1_pat == PAT_OFF || s1_pat == PAT_G) begin
                    if (dwell >= D_GB)
                        e_dwell = 1'b1;
                    else if ((s1_pat == PAT_G) != exp_g)
                        e_dwell = 1'b1;
                end else if (s1_pat == PAT_Y) begin
                    if (dwell != D_GB)
                        e_dwell = 1'b1;
                    else
                        nx_phase = PH_YELLOW;
                end else begin
                    e_seq = 1'b1;
                end
            end
            PH_YELLOW: begin
                if (s1_pat == PAT_Y) begin
                    if (dwell >= D_Y)
                        e_dwell = 1'b1;
                end else if (s1_pat == PAT_R) begin
                    if (dwell != D_Y) begin
                        e_dwell = 1'b1;
                    end else begin
                        nx_phase   = PH_RED;
                        red_entry  = 1'b1;
                        round_done = round_ok;
                        if (dec_dig != D_RS)
                            e_seg = 1'b1;
                    end
                end else begin
                    e_seq = 1'b1;
                end
            end
            default: nx_phase = PH_UNSYNC;
        endcase
        // Illegal pins are a sequence fault once synchronised
        if (phase != PH_UNSYNC && !is_legal_pat(s1_pat))
            e_seq = 1'b1;
        // Display must show a real glyph, and "0" unless counting down
        if (!dec_vld)
            e_seg = 1'b1;
        else if (nx_phase != PH_RED && nx_phase != PH_UNSYNC
                 && dec_dig != 4'd0)
            e_seg = 1'b1;
    end

    assign err_any  = e_seq | e_dwell | e_seg;
    assign nx_dwell = (nx_phase != phase) ? 5'd1 : dwell_inc;

    // Phase tracker: any error drops back to UNSYNC and voids the round
    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= PH_UNSYNC;
            dwell    <= 5'd0;
            prev_dig <= 4'd0;
            idle_y   <= 1'b0;
            round_ok <= 1'b0;
            digit    <= 4'd0;
        end else if (s1_vld) begin
            prev_dig <= dec_dig;
            digit    <= dec_dig;
            if (err_any) begin
                phase    <= PH_UNSYNC;
                dwell    <= 5'd1;
                idle_y   <= 1'b0;
                round_ok <= 1'b0;
            end else begin
                phase    <= nx_phase;
                dwell    <= nx_dwell;
                idle_y   <= nx_idle_y;
                round_ok <= round_ok | red_entry;
            end
        end
    end

    // Error strobe, sticky flags (new error beats clear) and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse <= 1'b0;
            err_seq   <= 1'b0;
            err_dwell <= 1'b0;
            err_seg   <= 1'b0;
            err_count <= 8'd0;
            cycles_ok <= 8'd0;
        end else if (s1_vld) begin
            err_pulse <= err_any;
            err_seq   <= e_seq   | (err_seq   & ~s1_clr);
            err_dwell <= e_dwell | (err_dwell & ~s1_clr);
            err_seg   <= e_seg   | (err_seg   & ~s1_clr);
            if (err_any && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            if (round_done && !err_any)
                cycles_ok <= cycles_ok + 8'd1;
        end
    end

endmodule
